// File: rtl/vc_mux_n_sd_pipe.sv
// N-input same-domain valid/ready mux with a single registered output stage.
// A domain change drains the held message, then spends one zeroed scrub cycle.
module vc_mux_n_sd_pipe #(
  parameter int p_nbits     = 32,
  parameter int p_ninputs   = 4,
  parameter int p_sel_nbits = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           domain,
  input  logic [p_sel_nbits-1:0]         sel,
  input  logic [p_ninputs-1:0]           in_val,
  output logic [p_ninputs-1:0]           in_rdy,
  input  logic [p_ninputs*p_nbits-1:0]   in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_msg,
  output logic                           out_domain
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SCRUB = 2'd2
  } state_t;

  localparam logic [p_sel_nbits:0] NumInputs = (p_sel_nbits + 1)'(p_ninputs);

  state_t               state_q, state_d;
  logic                 dom_q, dom_d;
  logic [p_nbits-1:0]   msg_q, msg_d;

  logic                 match;
  logic                 sel_ok;
  logic                 take;
  logic                 sel_val;
  logic                 accept;
  logic [p_nbits-1:0]   sel_msg;

  assign match  = (domain == dom_q);
  assign sel_ok = ({1'b0, sel} < NumInputs);
  assign take   = match && ((state_q == EMPTY) || ((state_q == FULL) && out_rdy));

  // Only the selected, in-range channel is ever looked at.
  always_comb begin
    sel_val = 1'b0;
    sel_msg = '0;
    in_rdy  = '0;
    for (int unsigned i = 0; i < p_ninputs; i++) begin
      if (sel_ok && (sel == p_sel_nbits'(i))) begin
        sel_val   = in_val[i];
        sel_msg   = in_msg[i*p_nbits +: p_nbits];
        in_rdy[i] = take;
      end
    end
  end

  assign accept = sel_val && take;

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    msg_d   = msg_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          msg_d   = sel_msg;
          state_d = FULL;
        end else if (!match) begin
          state_d = SCRUB;
        end
      end
      FULL: begin
        if (out_rdy) begin
          if (accept) begin
            msg_d = sel_msg;
          end else begin
            msg_d   = '0;
            state_d = match ? EMPTY : SCRUB;
          end
        end
      end
      SCRUB: begin
        msg_d   = '0;
        dom_d   = domain;
        state_d = EMPTY;
      end
      default: begin
        msg_d   = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      dom_q   <= 1'b0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      msg_q   <= msg_d;
    end
  end

  assign out_val    = (state_q == FULL);
  assign out_msg    = msg_q;
  assign out_domain = dom_q;

endmodule

// File: tb/tb_vc_mux_n_sd_pipe.sv
// Bench for vc_mux_n_sd_pipe: directed scenarios plus randomized traffic
// checked against a queue-based model of the drain/scrub rules.
module tb_vc_mux_n_sd_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         domain;
  logic [1:0]   sel;
  logic [3:0]   in_val;
  logic [3:0]   in_rdy;
  logic [127:0] in_msg;
  logic         out_val;
  logic         out_rdy;
  logic [31:0]  out_msg;
  logic         out_domain;

  logic         domain3;
  logic [1:0]   sel3;
  logic [2:0]   in_val3;
  logic [2:0]   in_rdy3;
  logic [95:0]  in_msg3;
  logic         out_val3;
  logic         out_rdy3;
  logic [31:0]  out_msg3;
  logic         out_domain3;

  int checks = 0;
  int errors = 0;

  // Model: at most one held message, current label, and a pending scrub cycle.
  logic [31:0] m_q[$];
  logic        m_dom;
  bit          m_scrub;

  vc_mux_n_sd_pipe #(.p_nbits(32), .p_ninputs(4), .p_sel_nbits(2)) u_dut (
    .clk(clk), .reset(reset), .domain(domain), .sel(sel),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_domain(out_domain)
  );

  vc_mux_n_sd_pipe #(.p_nbits(32), .p_ninputs(3), .p_sel_nbits(2)) u_dut3 (
    .clk(clk), .reset(reset), .domain(domain3), .sel(sel3),
    .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
    .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3),
    .out_domain(out_domain3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_rdy();
    int s = int'(sel);
    if (m_scrub || (domain != m_dom) || s >= 4) return 4'b0000;
    if (m_q.size() == 0 || out_rdy) return 4'(1 << s);
    return 4'b0000;
  endfunction

  function automatic logic [33:0] exp_out();
    if (m_q.size() != 0) return {1'b1, m_q[0], m_dom};
    return {1'b0, 32'h0, m_dom};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_dom   = 1'b0;
    m_scrub = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] r;
    int s;
    r = exp_rdy();
    s = int'(sel);
    if (m_scrub) begin
      m_scrub = 1'b0;
      m_dom   = domain;
    end else begin
      if (m_q.size() != 0 && out_rdy) void'(m_q.pop_front());
      if ((r & in_val) != 4'b0000) m_q.push_back(in_msg[s*32 +: 32]);
      else if (m_q.size() == 0 && domain != m_dom) m_scrub = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int ch, input logic [31:0] v);
    in_msg[ch*32 +: 32] = v;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_val, out_msg, out_domain} !== 34'h0) begin
      errors++;
      $display("FAIL reset_out got val=%b msg=%h dom=%b want 0/0/0", out_val, out_msg, out_domain);
    end
    checks++;
    if (in_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL reset_rdy got %b want 0100", in_rdy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    sel = 2'd2; domain = 1'b0; out_rdy = 1'b1; in_val = 4'b0100;
    set_msg(2, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (in_rdy !== 4'b0100) begin
      errors++; $display("FAIL single_rdy got %b want 0100", in_rdy);
    end
    tick();
    in_val = 4'b0000;
    checks++;
    if ({out_val, out_msg, out_domain} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL single_out got val=%b msg=%h dom=%b want 1/deadbeef/0", out_val, out_msg, out_domain);
    end
    tick();
    checks++;
    if ({out_val, out_msg} !== 33'h0) begin
      errors++; $display("FAIL single_drain got val=%b msg=%h want 0/0", out_val, out_msg);
    end
  endtask

  task automatic test_streaming();
    sel = 2'd1; out_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_val = 4'b0010;
      set_msg(1, 32'(k));
      #1;
      checks++;
      if (in_rdy !== 4'b0010) begin
        errors++; $display("FAIL stream_rdy[%0d] got %b want 0010", k, in_rdy);
      end
      tick();
      checks++;
      if ({out_val, out_msg} !== {1'b1, 32'(k)}) begin
        errors++; $display("FAIL stream_out[%0d] got val=%b msg=%h want 1/%h", k, out_val, out_msg, 32'(k));
      end
    end
    in_val = 4'b0000;
    tick();
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL stream_end got val=%b want 0", out_val);
    end
  endtask

  task automatic test_backpressure();
    sel = 2'd0; out_rdy = 1'b1; in_val = 4'b0001;
    set_msg(0, 32'h55);
    tick();
    in_val = 4'b0000; out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_rdy !== 4'b0000) begin
        errors++; $display("FAIL bp_rdy[%0d] got %b want 0000", k, in_rdy);
      end
      tick();
      checks++;
      if ({out_val, out_msg} !== {1'b1, 32'h55}) begin
        errors++; $display("FAIL bp_hold[%0d] got val=%b msg=%h want 1/55", k, out_val, out_msg);
      end
    end
    out_rdy = 1'b1; in_val = 4'b0001;
    set_msg(0, 32'hAA);
    #1;
    checks++;
    if (in_rdy !== 4'b0001) begin
      errors++; $display("FAIL bp_release_rdy got %b want 0001", in_rdy);
    end
    tick();
    checks++;
    if ({out_val, out_msg} !== {1'b1, 32'hAA}) begin
      errors++; $display("FAIL bp_handoff got val=%b msg=%h want 1/aa", out_val, out_msg);
    end
    in_val = 4'b0000;
    tick();
  endtask

  task automatic test_domain_full();
    sel = 2'd3; out_rdy = 1'b1; in_val = 4'b1000;
    set_msg(3, 32'h1234);
    tick();
    in_val = 4'b0000; out_rdy = 1'b0; domain = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (in_rdy !== 4'b0000) begin
        errors++; $display("FAIL domfull_rdy[%0d] got %b want 0000", k, in_rdy);
      end
      tick();
      checks++;
      if ({out_val, out_msg, out_domain} !== {1'b1, 32'h1234, 1'b0}) begin
        errors++; $display("FAIL domfull_hold[%0d] got val=%b msg=%h dom=%b want 1/1234/0", k, out_val, out_msg, out_domain);
      end
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 4'b0000) begin
      errors++; $display("FAIL domfull_drain_rdy got %b want 0000", in_rdy);
    end
    tick();
    checks++;
    if ({out_val, out_msg, in_rdy} !== 37'h0) begin
      errors++; $display("FAIL domfull_scrub got val=%b msg=%h rdy=%b want 0/0/0000", out_val, out_msg, in_rdy);
    end
    tick();
    checks++;
    if ({out_val, out_domain, in_rdy} !== {1'b0, 1'b1, 4'b1000}) begin
      errors++; $display("FAIL domfull_after got val=%b dom=%b rdy=%b want 0/1/1000", out_val, out_domain, in_rdy);
    end
  endtask

  task automatic test_domain_bounce();
    domain = 1'b0;
    tick();
    tick();
    domain = 1'b1;
    tick();
    checks++;
    if ({out_val, out_domain} !== 2'b00) begin
      errors++; $display("FAIL bounce_scrub got val=%b dom=%b want 0/0", out_val, out_domain);
    end
    domain = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 4'b0000) begin
      errors++; $display("FAIL bounce_scrub_rdy got %b want 0000", in_rdy);
    end
    tick();
    checks++;
    if ({out_domain, in_rdy} !== {1'b0, 4'b1000}) begin
      errors++; $display("FAIL bounce_after got dom=%b rdy=%b want 0/1000", out_domain, in_rdy);
    end
    tick();
    checks++;
    if (in_rdy !== 4'b1000) begin
      errors++; $display("FAIL bounce_settled got rdy=%b want 1000", in_rdy);
    end
  endtask

  task automatic test_reset_midflight();
    sel = 2'd2; domain = 1'b0; out_rdy = 1'b1; in_val = 4'b0100;
    set_msg(2, 32'hFFFF_FFFF);
    tick();
    in_val = 4'b0000; out_rdy = 1'b0;
    checks++;
    if ({out_val, out_msg} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL rstmid_full got val=%b msg=%h want 1/ffffffff", out_val, out_msg);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({out_val, out_msg, out_domain} !== 34'h0) begin
      errors++; $display("FAIL rstmid_async got val=%b msg=%h dom=%b want 0/0/0", out_val, out_msg, out_domain);
    end
    #1 reset = 1'b0;
    model_reset();
    out_rdy = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) domain = ~domain;
      sel     = 2'($urandom);
      in_val  = 4'($urandom);
      in_msg  = {$urandom, $urandom, $urandom, $urandom};
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_rdy !== exp_rdy()) begin
        errors++; $display("FAIL rand_rdy[%0d] got %b want %b", c, in_rdy, exp_rdy());
      end
      tick();
      checks++;
      if ({out_val, out_msg, out_domain} !== exp_out()) begin
        errors++; $display("FAIL rand_out[%0d] got %h want %h", c, {out_val, out_msg, out_domain}, exp_out());
      end
    end
    in_val = 4'b0000;
  endtask

  task automatic test_oor();
    sel3 = 2'd3; in_val3 = 3'b111; out_rdy3 = 1'b1; domain3 = 1'b0;
    in_msg3 = {$urandom, $urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_rdy3 !== 3'b000) begin
        errors++; $display("FAIL oor_rdy[%0d] got %b want 000", k, in_rdy3);
      end
      tick();
      checks++;
      if ({out_val3, out_msg3} !== 33'h0) begin
        errors++; $display("FAIL oor_out[%0d] got val=%b msg=%h want 0/0", k, out_val3, out_msg3);
      end
    end
    domain3 = 1'b1;
    tick();
    tick();
    checks++;
    if (out_domain3 !== 1'b1) begin
      errors++; $display("FAIL oor_scrub_dom got %b want 1", out_domain3);
    end
    sel3 = 2'd0;
    #1;
    checks++;
    if (in_rdy3 !== 3'b001) begin
      errors++; $display("FAIL oor_inrange_rdy got %b want 001", in_rdy3);
    end
  endtask

  initial begin
    reset = 1'b1; domain = 1'b0; sel = 2'd2; in_val = 4'b0000; in_msg = '0; out_rdy = 1'b1;
    domain3 = 1'b0; sel3 = 2'd3; in_val3 = 3'b000; in_msg3 = '0; out_rdy3 = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_domain_full();
    test_domain_bounce();
    test_reset_midflight();
    test_random();
    test_oor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
